// File: rtl/amp_share_arbiter.sv
// Round-robin arbiter sharing one amplifier input channel between NREQ front-ends.
// Each tenure is bounded by a hold timer; a timed-out requester stays masked until it drops req.
module amp_share_arbiter #(
    parameter int NREQ     = 4,
    parameter int OWN_W    = 2,
    parameter int MAX_HOLD = 12,
    parameter int HOLD_W   = 4
) (
    input  logic             mclk,
    input  logic             resetb,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  done,
    output logic [NREQ-1:0]  grant,
    output logic             busy,
    output logic [OWN_W-1:0] owner,
    output logic             timeout
);

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_RELEASE} state_t;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic              busy_q, busy_d;
    logic [OWN_W-1:0]  owner_q, owner_d;
    logic [OWN_W-1:0]  last_q, last_d;
    logic              timeout_q, timeout_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [NREQ-1:0]   mask_q, mask_d;

    logic [NREQ-1:0]   elig;
    logic              win_found;
    logic [OWN_W-1:0]  win_idx;
    logic              own_done, own_req, hold_lim;
    logic              end_tenure, load;
    int                idx;

    assign elig     = req & ~mask_q;
    assign own_done = done[owner_q];
    assign own_req  = req[owner_q];
    assign hold_lim = (hold_q == HOLD_W'(MAX_HOLD - 1));

    // Rotating priority: search starts just after the previous winner.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = int'(last_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!win_found && elig[idx]) begin
                win_found = 1'b1;
                win_idx   = OWN_W'(idx);
            end
        end
    end

    always_ff @(posedge mclk or negedge resetb) begin
        if (!resetb) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            owner_q   <= '0;
            last_q    <= OWN_W'(NREQ - 1);
            timeout_q <= 1'b0;
            hold_q    <= '0;
            mask_q    <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            timeout_q <= timeout_d;
            hold_q    <= hold_d;
            mask_q    <= mask_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        end_tenure = 1'b0;
        load       = 1'b0;
        case (state_q)
            S_GRANT: begin
                end_tenure = own_done || !own_req || hold_lim;
                if (end_tenure) state_d = S_RELEASE;
            end
            S_IDLE, S_RELEASE: begin
                load    = win_found;
                state_d = win_found ? S_GRANT : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        grant_d   = '0;
        owner_d   = owner_q;
        last_d    = last_q;
        hold_d    = '0;
        timeout_d = 1'b0;
        // Done and req-drop take priority over the hold limit, so only a true cut masks.
        timeout_d = (state_q == S_GRANT) && hold_lim && own_req && !own_done;
        mask_d    = mask_q & req;
        if (timeout_d) mask_d[owner_q] = 1'b1;
        if (load) begin
            grant_d[win_idx] = 1'b1;
            owner_d          = win_idx;
            last_d           = win_idx;
        end else if (state_q == S_GRANT && !end_tenure) begin
            grant_d = grant_q;
            hold_d  = (&hold_q) ? hold_q : hold_q + 1'b1;
        end
        busy_d = (state_d == S_GRANT);
    end

    assign grant   = grant_q;
    assign busy    = busy_q;
    assign owner   = owner_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_amp_share_arbiter.sv
// Randomized and directed bench for amp_share_arbiter against a tenure-level reference model.
module tb_amp_share_arbiter;

    localparam int NREQ     = 4;
    localparam int OWN_W    = 2;
    localparam int MAX_HOLD = 12;
    localparam int HOLD_W   = 4;

    logic             mclk = 1'b0;
    logic             resetb = 1'b0;
    logic [NREQ-1:0]  req = '0;
    logic [NREQ-1:0]  done = '0;
    logic [NREQ-1:0]  grant;
    logic             busy;
    logic [OWN_W-1:0] owner;
    logic             timeout;

    amp_share_arbiter #(
        .NREQ(NREQ), .OWN_W(OWN_W), .MAX_HOLD(MAX_HOLD), .HOLD_W(HOLD_W)
    ) dut (
        .mclk(mclk), .resetb(resetb), .req(req), .done(done),
        .grant(grant), .busy(busy), .owner(owner), .timeout(timeout)
    );

    always #5 mclk = ~mclk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: who holds the channel, for how many cycles, and who is barred.
    int          m_cur;   // current grantee, -1 when none
    int          m_ten;   // cycles granted so far in this tenure
    int          m_last;  // most recent winner
    int          m_own;   // owner index presented downstream
    bit          m_tmo;
    bit [NREQ-1:0] m_mask;

    int owner_seq[$];
    bit busy_prev;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cur = -1; m_ten = 0; m_last = NREQ - 1; m_own = 0; m_tmo = 0; m_mask = '0;
    endtask

    task automatic model_step(input logic [NREQ-1:0] r, input logic [NREQ-1:0] d);
        bit [NREQ-1:0] old_mask;
        int            w;
        old_mask = m_mask;
        m_tmo    = 0;
        m_mask   = m_mask & r;
        if (m_cur >= 0) begin
            if (d[m_cur] || !r[m_cur]) begin
                m_cur = -1;
            end else if (m_ten == MAX_HOLD) begin
                m_tmo = 1;
                m_mask[m_cur] = 1'b1;
                m_cur = -1;
            end else begin
                m_ten++;
            end
        end else begin
            w = -1;
            for (int k = 1; k <= NREQ; k++) begin
                int c;
                c = (m_last + k) % NREQ;
                if (w < 0 && r[c] && !old_mask[c]) w = c;
            end
            if (w >= 0) begin
                m_cur = w; m_last = w; m_own = w; m_ten = 1;
            end
        end
    endtask

    task automatic check_outputs(input string ctx);
        logic [NREQ-1:0] g_exp;
        g_exp = (m_cur >= 0) ? NREQ'(1 << m_cur) : '0;
        check({ctx, ".grant"},   32'(grant),   32'(g_exp));
        check({ctx, ".busy"},    32'(busy),    32'(m_cur >= 0));
        check({ctx, ".owner"},   32'(owner),   32'(m_own));
        check({ctx, ".timeout"}, 32'(timeout), 32'(m_tmo));
    endtask

    task automatic cycle(input string ctx, input logic [NREQ-1:0] r, input logic [NREQ-1:0] d);
        @(negedge mclk);
        req  = r;
        done = d;
        @(posedge mclk);
        model_step(r, d);
        #1;
        check_outputs(ctx);
        if (busy && !busy_prev) owner_seq.push_back(int'(owner));
        busy_prev = busy;
    endtask

    initial begin
        logic [NREQ-1:0] r, d, flips;
        int dens;

        model_reset();
        busy_prev = 0;
        resetb = 1'b0;
        repeat (2) @(posedge mclk);
        #1;
        check_outputs("reset");
        @(negedge mclk);
        resetb = 1'b1;

        // Round robin with every owner releasing after two grant cycles.
        owner_seq.delete();
        for (int i = 0; i < 16; i++) begin
            d = (m_cur >= 0 && m_ten == 2) ? NREQ'(1 << m_cur) : '0;
            cycle("rr", 4'b1111, d);
        end
        begin
            int exp_seq[5] = '{0, 1, 2, 3, 0};
            check("rr.count", 32'(owner_seq.size() >= 5), 32'(1));
            for (int i = 0; i < 5 && i < owner_seq.size(); i++)
                check("rr.seq", 32'(owner_seq[i]), 32'(exp_seq[i]));
        end
        repeat (3) cycle("idle", 4'b0000, 4'b0000);

        // Timeout on a sole requester, then drop-and-reassert to clear the mask.
        repeat (30) cycle("tmo", 4'b0100, 4'b0000);
        cycle("tmo.drop", 4'b0000, 4'b0000);
        repeat (5) cycle("tmo.re", 4'b0100, 4'b0000);
        repeat (3) cycle("idle", 4'b0000, 4'b0000);

        // done lands on the 12th grant cycle: release without timeout or mask.
        for (int i = 0; i < 12; i++) cycle("dt", 4'b0010, 4'b0000);
        cycle("dt.done", 4'b0010, 4'b0010);
        check("dt.no_timeout", 32'(timeout), 32'(0));
        repeat (3) cycle("dt.regrant", 4'b0010, 4'b0000);
        check("dt.regrant_grant", 32'(grant), 32'(4'b0010));
        repeat (3) cycle("idle", 4'b0000, 4'b0000);

        // Owner 3 drops req mid-tenure while requester 0 waits.
        repeat (5) cycle("drop", 4'b1000, 4'b0000);
        repeat (2) cycle("drop", 4'b1001, 4'b0000);
        repeat (4) cycle("drop.pend", 4'b0001, 4'b0000);

        // Asynchronous reset between edges while a grant is active.
        repeat (3) cycle("areset.pre", 4'b1111, 4'b0000);
        @(negedge mclk);
        #2;
        resetb = 1'b0;
        #1;
        model_reset();
        check_outputs("areset");
        @(posedge mclk);
        #1;
        check_outputs("areset.hold");
        @(negedge mclk);
        resetb = 1'b1;
        busy_prev = 0;
        repeat (3) cycle("areset.post", 4'b1111, 4'b0000);

        // Random traffic with varying request density and sporadic done pulses.
        r = '0;
        for (int ph = 0; ph < 6; ph++) begin
            dens = 2 + ph;
            for (int i = 0; i < 400; i++) begin
                flips = '0;
                for (int b = 0; b < NREQ; b++)
                    flips[b] = ($urandom_range(0, dens * 3) == 0);
                r = r ^ flips;
                d = ($urandom_range(0, 5) == 0) ? NREQ'($urandom()) : '0;
                cycle("rand", r, d);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/amp_share_arbiter.md
Name: amp_share_arbiter

Overview:
Round-robin arbiter that shares one amplifier input channel (the shared `marty`-style effects datapath) between up to NREQ guitarist front-ends. It sits between the guitarist modules and the shared datapath and produces one-hot grants plus an owner index for the downstream mux. It bounds each tenure with a hold timer and masks a timed-out requester until it drops its request.

Parameters:
NREQ, 4, number of requesters (2..8)
OWN_W, 2, width of owner index (must equal ceil(log2(NREQ)))
MAX_HOLD, 12, maximum grant tenure in cycles (1..2^HOLD_W-1)
HOLD_W, 4, width of hold counter

Ports:
mclk  input  1  clock, rising edge
resetb  input  1  asynchronous active-low reset
req  input  NREQ  per-requester access request, level
done  input  NREQ  per-requester release strobe, 1-cycle pulse
grant  output  NREQ  one-hot grant, registered
busy  output  1  high while any grant is active, registered
owner  output  OWN_W  index of current grantee, registered; holds last value when idle
timeout  output  1  1-cycle pulse when a tenure is cut by MAX_HOLD

Behaviour:
- Reset (resetb low, async): state=IDLE, grant=0, busy=0, owner=0, timeout=0, hold_cnt=0, mask=0, last=NREQ-1 (so requester 0 wins first).
- Eligible vector elig = req & ~mask. Winner = first set bit of elig searching last+1, last+2, ... modulo NREQ.
- FSM states: IDLE, GRANT, RELEASE.
- IDLE: if elig!=0 at edge k, the next edge gives: state=GRANT, grant=onehot(winner), owner=winner, last=winner, busy=1, hold_cnt=0. Grant is visible 1 cycle after req.
- GRANT: hold_cnt increments each cycle, saturating.
  - End conditions, checked at each edge in priority order:
    - done[owner]=1 -> RELEASE.
    - req[owner]=0 -> RELEASE.
    - hold_cnt==MAX_HOLD-1 -> RELEASE, timeout=1 for one cycle, mask[owner]=1.
  - If done and the timeout limit occur in the same cycle, done wins: no timeout pulse and no mask set.
  - done/req from non-owners are ignored.
  - A grant lasts at most MAX_HOLD cycles.
- RELEASE: exactly 1 cycle with grant=0 and busy=0. At its edge, if elig!=0, go to GRANT with a new winner (same load as from IDLE). Otherwise go to IDLE. The minimum gap between grants is 1 cycle.
- Mask: mask[i] clears on any edge where req[i]=0. The clear applies in every state.
- Invariant: grant is one-hot or zero. busy == |grant.
- Mid-operation reset: grant drops immediately (async) and all state returns to reset values.
- A requester that is the sole requester re-wins after RELEASE unless it is masked.

Test Plan:
- Single request: after reset, req=0001 at cycle 2 -> grant=0001, owner=0, busy=1 at cycle 3. done[0] pulse at cycle 6 -> grant=0 at cycle 7, IDLE at cycle 8.
- Round-robin: req=1111 held, each owner pulses done after 2 grant cycles -> owner sequence 0,1,2,3,0, with exactly 1 idle cycle between grants.
- Timeout: req=0100 held, no done -> grant=0100 for exactly 12 cycles, then timeout=1 for 1 cycle and grant=0. No regrant while req[2] stays high. Drop req[2] for 1 cycle and reassert -> grant=0100 again.
- Simultaneous done and timeout: done[1] on the 12th grant cycle -> timeout stays 0 and mask[1] stays 0. With req[1] still high and no other requesters, grant=0010 is reissued after the 1-cycle RELEASE.
- Request drop: owner 3 deasserts req mid-tenure at cycle 5 of its tenure -> grant=0 next edge. The pending requester 0 is granted 1 cycle later.
- Async reset: assert resetb=0 mid-GRANT between clock edges -> grant=0, busy=0, owner=0 immediately. After release with req=1111 -> requester 0 is granted first.
